// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-side arbiter.
// Provides the default sizing, the credit-counter width helper and the
// requester index type used by the arbiter and its surroundings.
package fifo_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  // Counter must hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] idx_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_sel.sv
// Round-robin priority search: first set bit of valid at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no bit of valid is set.
// Ports: valid (request vector), ptr (search start), found (any winner), idx (winner).
module rr_priority_sel #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  // Walk the offsets from farthest to nearest so the nearest valid position
  // relative to ptr is the last one written, i.e. it wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (valid[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers, round-robin, credit-gated.
// Latency: transfer in cycle t appears as write_en/data_in/grant_id in cycle t+1.
// Backpressure: req_ready all low while credits==0 or reset; requests wait, no loss.
// Ports: clk/reset; req_valid/req_data/req_ready producer side; fifo_read_en,
//        fifo_empty, fifo_full observed FIFO status; write_en/data_in/grant_id
//        registered write port; credits free-slot count; overflow_err sticky.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int CRED_W     = credit_width(FIFO_DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_read_en,
  input  logic                          fifo_empty,
  input  logic                          fifo_full,
  output logic                          write_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [IDX_W-1:0]              grant_id,
  output logic [CRED_W-1:0]             credits,
  output logic                          overflow_err
);

  logic [IDX_W-1:0]      rr_ptr;
  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  logic                  issue;
  logic                  free;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  rr_priority_sel #(.N(NUM_REQ)) u_sel (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (win_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant uses the registered credit count, so a slot freed this cycle only
  // becomes usable next cycle. Reset gating keeps req_ready low before the
  // first reset edge has initialised the counter.
  assign issue = found && (credits != '0) && !reset;
  assign free  = fifo_read_en && !fifo_empty;

  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      credits      <= CRED_W'(FIFO_DEPTH);
      write_en     <= 1'b0;
      data_in      <= '0;
      grant_id     <= '0;
      overflow_err <= 1'b0;
    end else begin
      write_en <= issue;
      if (issue) begin
        data_in  <= words[win_idx];
        grant_id <= win_idx;
        rr_ptr   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      end

      // issue implies credits!=0, so no underflow; a free at full count is
      // dropped so the counter never exceeds the FIFO depth.
      if (issue && !free) begin
        credits <= credits - CRED_W'(1);
      end else if (free && !issue && credits != CRED_W'(FIFO_DEPTH)) begin
        credits <= credits + CRED_W'(1);
      end

      if (write_en && fifo_full) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_read_en;
  logic        fifo_empty;
  logic        fifo_full;
  logic        write_en;
  logic [7:0]  data_in;
  logic [1:0]  grant_id;
  logic [3:0]  credits;
  logic        overflow_err;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_read_en (fifo_read_en),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .write_en     (write_en),
    .data_in      (data_in),
    .grant_id     (grant_id),
    .credits      (credits),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        rd;
    logic        emp;
    logic [3:0]  rdy;
    logic [3:0]  cred;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[25];
  int   errors = 0;
  int   checks = 0;
  logic exp_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive just after the rising edge, check 2 ns later.
  task automatic cycle(input string name, input logic rst, input logic [3:0] vld,
                       input logic [31:0] dat, input logic rd, input logic emp,
                       input logic full, input logic [3:0] exp_rdy,
                       input logic [3:0] exp_cred, input logic exp_ovf);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    req_valid    = vld;
    req_data     = dat;
    fifo_read_en = rd;
    fifo_empty   = emp;
    fifo_full    = full;
    #1;
    chk({name, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({name, ".credits"}, 32'(credits), 32'(exp_cred));
    chk({name, ".write_en"}, 32'(write_en), 32'(exp_we));
    chk({name, ".overflow_err"}, 32'(overflow_err), 32'(exp_ovf));
    if (write_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s.sb: write with data %0h but no write expected", name, data_in);
      end else begin
        e = sb.pop_front();
        chk({name, ".data_in"}, 32'(data_in), 32'(e.d));
        chk({name, ".grant_id"}, 32'(grant_id), 32'(e.id));
      end
    end
    exp_we = (exp_rdy != 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        e.d  = dat[i*8 +: 8];
        e.id = 2'(i);
        sb.push_back(e);
      end
    end
  endtask

  localparam logic [31:0] R  = 32'hA3A2A1A0;
  localparam logic [31:0] S1 = 32'hA3A255A0;
  localparam logic [31:0] S2 = 32'hA3A266A0;
  localparam logic [31:0] B  = 32'hB3B2B1B0;

  initial begin
    reset = 1'b1; req_valid = 4'hF; req_data = R;
    fifo_read_en = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0;

    //            vld   dat rd    emp   rdy   cred
    // rotation, credits drain to zero
    tbl[0]  = '{4'hF, R,  1'b0, 1'b0, 4'h1, 4'd8};
    tbl[1]  = '{4'hF, R,  1'b0, 1'b0, 4'h2, 4'd7};
    tbl[2]  = '{4'hF, R,  1'b0, 1'b0, 4'h4, 4'd6};
    tbl[3]  = '{4'hF, R,  1'b0, 1'b0, 4'h8, 4'd5};
    tbl[4]  = '{4'hF, R,  1'b0, 1'b0, 4'h1, 4'd4};
    tbl[5]  = '{4'hF, R,  1'b0, 1'b0, 4'h2, 4'd3};
    tbl[6]  = '{4'hF, R,  1'b0, 1'b0, 4'h4, 4'd2};
    tbl[7]  = '{4'hF, R,  1'b0, 1'b0, 4'h8, 4'd1};
    tbl[8]  = '{4'hF, R,  1'b0, 1'b0, 4'h0, 4'd0};
    tbl[9]  = '{4'hF, R,  1'b0, 1'b0, 4'h0, 4'd0};
    // stall, one read frees one slot, one grant at pointer 0
    tbl[10] = '{4'hF, R,  1'b1, 1'b0, 4'h0, 4'd0};
    tbl[11] = '{4'hF, R,  1'b0, 1'b0, 4'h1, 4'd1};
    tbl[12] = '{4'hF, R,  1'b0, 1'b0, 4'h0, 4'd0};
    // refill to 3, then simultaneous issue+free, then read while empty
    tbl[13] = '{4'h0, R,  1'b1, 1'b0, 4'h0, 4'd0};
    tbl[14] = '{4'h0, R,  1'b1, 1'b0, 4'h0, 4'd1};
    tbl[15] = '{4'h0, R,  1'b1, 1'b0, 4'h0, 4'd2};
    tbl[16] = '{4'hF, R,  1'b1, 1'b0, 4'h2, 4'd3};
    tbl[17] = '{4'h0, R,  1'b1, 1'b1, 4'h0, 4'd3};
    tbl[18] = '{4'h0, R,  1'b0, 1'b0, 4'h0, 4'd3};
    // sparse requester 2, then all valid shows pointer at 3
    tbl[19] = '{4'h4, S1, 1'b0, 1'b0, 4'h4, 4'd3};
    tbl[20] = '{4'h0, S1, 1'b0, 1'b0, 4'h0, 4'd2};
    tbl[21] = '{4'h4, S2, 1'b0, 1'b0, 4'h4, 4'd2};
    tbl[22] = '{4'h0, S2, 1'b0, 1'b0, 4'h0, 4'd1};
    tbl[23] = '{4'hF, R,  1'b0, 1'b0, 4'h8, 4'd1};
    tbl[24] = '{4'hF, R,  1'b0, 1'b0, 4'h0, 4'd0};

    // reset held two cycles with all producers requesting
    cycle("rst0", 1'b1, 4'hF, R, 1'b0, 1'b0, 1'b0, 4'h0, 4'd8, 1'b0);
    cycle("rst1", 1'b1, 4'hF, R, 1'b0, 1'b0, 1'b0, 4'h0, 4'd8, 1'b0);

    for (int i = 0; i < 25; i++) begin
      cycle($sformatf("vec%0d", i), 1'b0, tbl[i].vld, tbl[i].dat, tbl[i].rd,
            tbl[i].emp, 1'b0, tbl[i].rdy, tbl[i].cred, 1'b0);
    end

    // reset during a burst drops the in-flight write and restores credits
    cycle("mid_rst_a", 1'b1, 4'hF, B, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
    cycle("mid_rst_b", 1'b0, 4'hF, B, 1'b0, 1'b0, 1'b0, 4'h1, 4'd8, 1'b0);
    cycle("mid_rst_c", 1'b1, 4'hF, B, 1'b0, 1'b0, 1'b0, 4'h0, 4'd7, 1'b0);
    cycle("mid_rst_d", 1'b0, 4'h0, B, 1'b0, 1'b0, 1'b0, 4'h0, 4'd8, 1'b0);

    // full without a write is harmless; full with a write sets the sticky flag
    cycle("ovf_a", 1'b0, 4'h4, B, 1'b0, 1'b0, 1'b1, 4'h4, 4'd8, 1'b0);
    cycle("ovf_b", 1'b0, 4'h0, B, 1'b0, 1'b0, 1'b1, 4'h0, 4'd7, 1'b0);
    cycle("ovf_c", 1'b0, 4'h0, B, 1'b0, 1'b0, 1'b0, 4'h0, 4'd7, 1'b1);
    cycle("ovf_d", 1'b0, 4'h0, B, 1'b0, 1'b0, 1'b0, 4'h0, 4'd7, 1'b1);
    cycle("ovf_e", 1'b1, 4'h0, B, 1'b0, 1'b0, 1'b0, 4'h0, 4'd7, 1'b1);
    cycle("ovf_f", 1'b0, 4'h0, B, 1'b0, 1'b0, 1'b0, 4'h0, 4'd8, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side controller that shares the single write port of one `syn_fifo` between `NUM_REQ` producers. It tracks free FIFO slots with a credit counter, so no write is ever issued into a full FIFO, and it drives registered `write_en` and `data_in` into the FIFO. It sits between the producer blocks and the FIFO. The FIFO's read side is only observed, never driven.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers; minimum 2.
- `DATA_WIDTH`, 8: width of the data word; must equal the FIFO data width.
- `FIFO_DEPTH`, 8: number of FIFO entries; initial credit count.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input `NUM_REQ`: producer i has a word.
- `req_data` input `NUM_REQ*DATA_WIDTH`: slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` output `NUM_REQ`: one-hot or zero; combinational accept for producer i.
- `fifo_read_en` input 1: observed FIFO `read_en`.
- `fifo_empty` input 1: observed FIFO `empty`.
- `fifo_full` input 1: observed FIFO `full`; used only for the error check.
- `write_en` output 1: registered FIFO write strobe.
- `data_in` output `DATA_WIDTH`: registered FIFO write data.
- `grant_id` output `$clog2(NUM_REQ)`: registered index of the producer whose word is on `data_in`.
- `credits` output `$clog2(FIFO_DEPTH+1)`: current free-slot count.
- `overflow_err` output 1: sticky flag; set when `write_en && fifo_full`.

## Operation
- **Handshake:** transfer i occurs in a cycle where `req_valid[i] && req_ready[i]`. A producer holds `req_valid` and its data until that cycle.
- **Grant rule:** `req_ready[i]` = (i is the first asserted `req_valid` searching upward from `rr_ptr`, wrapping at `NUM_REQ-1` → 0) AND (`credits != 0`). At most one bit is set. `req_ready` may depend combinationally on `req_valid`.
- **Pointer:** on a transfer to i, `rr_ptr` ← (i+1) mod `NUM_REQ`. With no transfer, `rr_ptr` holds.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,N-1,0.
- **Credits:**
  - issue = any transfer this cycle.
  - free = `fifo_read_en && !fifo_empty`.
  - `credits` ← `credits` − issue + free.
  - Simultaneous issue and free: `credits` unchanged.
  - A free in the current cycle does not enable a grant in that same cycle, since the grant uses the registered `credits`.
  - Saturation: `credits` never exceeds `FIFO_DEPTH` and never goes below 0. A free when `credits==FIFO_DEPTH` is ignored (cannot occur with a correct FIFO).
- **Credits zero:** all `req_ready` low. Requests wait with no loss and `rr_ptr` frozen.
- **Error check:** `overflow_err` ← 1 on any cycle with `write_en && fifo_full`. It clears only on reset and indicates a depth mismatch.
- **FSM:** none beyond the registers listed. Behaviour is fully described by `rr_ptr`, `credits`, the output registers and `overflow_err`.

## Timing
- **Reset values:**
  - `write_en` = 0, `data_in` = 0, `grant_id` = 0.
  - `credits` = `FIFO_DEPTH`, `overflow_err` = 0, `rr_ptr` = 0.
  - `req_ready` = 0 while `reset` is high.
- **Latency:** a transfer in cycle t gives `write_en`=1, `data_in` = the word, `grant_id`=i in cycle t+1. One write per cycle is sustained while credits remain.
- **Write deassert:** `write_en` = 0 in any cycle following a cycle with no transfer.
- **Reset mid-operation:** an in-flight registered write is dropped and credits return to `FIFO_DEPTH`. The FIFO must share the same `reset`.

## Structure
- **Package `fifo_arb_pkg`:**
  - default `NUM_REQ`, `DATA_WIDTH` and `FIFO_DEPTH` constants.
  - credit-width function, `clog2(depth+1)`.
  - `idx_t` typedef for requester index.
- **Sub-module `rr_priority_sel`:** combinational, given the `req_valid` vector and `rr_ptr`, it returns a found flag and the winning index. It is instantiated once.
- The top level holds the credit counter, pointer and output registers.

## Test plan
1. **Reset:** hold `reset` 2 cycles with `req_valid`=4'b1111 → `req_ready`=0, `write_en`=0, `credits`=8, `overflow_err`=0.
2. **Rotation:** all four valid with data 0xA0..0xA3 and no FIFO reads → `grant_id` sequence 0,1,2,3,0,1,2,3 on cycles t+1…t+8. After 8 writes `credits`=0 and `req_ready`=0 thereafter.
3. **Stall and resume:** with `credits`=0, pulse `fifo_read_en` one cycle (`fifo_empty`=0) → `credits`=1 the next cycle. Exactly one grant goes to the next pointer position, then `credits` returns to 0.
4. **Simultaneous events:** with `credits`=3, transfer and counted read in the same cycle → `credits` stays 3. Read with `fifo_empty`=1 → not counted.
5. **Sparse requests:** only `req_valid[2]` toggling with data 0x55, 0x66 → both written in order with `grant_id`=2, and `rr_ptr` advances to 3 each time.
6. **Reset mid-burst and error:** assert `reset` during a burst with `write_en`=1 → next cycle `write_en`=0 and `credits`=8. Force `fifo_full`=1 while `write_en`=1 → `overflow_err`=1 and it stays set until reset.
